vga_fb_arbiter: RTL and testbench

Time-slot arbiter that shares one single-port synchronous frame-buffer RAM between the VGA display read path and a pixel writer (camera/processing stage). Sits between the VGA timing driver and the VGA colour-output stage. Display reads are scheduled deterministically from the driver's x/y counters and always win. Writer traffic is buffered in a one-entry hold register and drained into free slots. The block delivers 12-bit pixel data plus delayed sync/video strobes that are aligned to that data.

---
 rtl/vga_pkg.sv | 13 +
 rtl/vga_sig_delay.sv | 25 ++
 rtl/vga_fb_arbiter.sv | 147 ++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer path.
package vga_pkg;

  localparam int unsigned PIX_DATA_W = 12;
  localparam int unsigned PIX_LAT    = 3;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_e;

endpackage

// File: rtl/vga_sig_delay.sv
// N-stage resettable shift register used to align strobes with pixel data.
module vga_sig_delay #(
  parameter int unsigned W = 1,
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Time-slot arbiter sharing a single-port frame-buffer RAM between display reads and a writer.
// Optional 2x upscale: define VGA_FB_SCALE2X_EN.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned SRC_W  = 320,
  parameter int unsigned SRC_H  = 240,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = PIX_DATA_W
) (
  input  logic              i_clk25m,
  input  logic              i_rstn_clk25m,
  input  logic [9:0]        i_VGA_x,
  input  logic [9:0]        i_VGA_y,
  input  logic              i_VGA_video,
  input  logic              i_VGA_hsync,
  input  logic              i_VGA_vsync,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_drop,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [DATA_W-1:0] o_pixel_data,
  output logic              o_video_d,
  output logic              o_hsync_d,
  output logic              o_vsync_d
);

  localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(SRC_W * SRC_H);

  logic              read_slot;
  logic [9:0]        src_x;
  logic [9:0]        src_y;
  logic [ADDR_W-1:0] rd_addr;

`ifdef VGA_FB_SCALE2X_EN
  localparam int unsigned SHIFT = 1;
  // Odd x columns re-show the pixel fetched on the preceding even column.
  assign read_slot = i_VGA_video & ~i_VGA_x[0];
`else
  localparam int unsigned SHIFT = 0;
  assign read_slot = i_VGA_video;
`endif

  assign src_x   = i_VGA_x >> SHIFT;
  assign src_y   = i_VGA_y >> SHIFT;
  assign rd_addr = ADDR_W'(src_y) * ADDR_W'(SRC_W) + ADDR_W'(src_x);

  logic              hold_valid;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic              wr_accept;
  logic              wr_in_range;
  slot_e             slot;

  assign o_wr_ready  = ~hold_valid;
  assign wr_accept   = i_wr_valid & o_wr_ready;
  assign wr_in_range = {1'b0, i_wr_addr} < PIX_TOTAL;

  always_comb begin
    slot = SLOT_IDLE;
    if (read_slot)       slot = SLOT_READ;
    else if (hold_valid) slot = SLOT_WRITE;
  end

  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m) begin
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
    end else begin
      unique case (slot)
        SLOT_READ: begin
          o_ram_en   <= 1'b1;
          o_ram_we   <= 1'b0;
          o_ram_addr <= rd_addr;
        end
        SLOT_WRITE: begin
          o_ram_en    <= 1'b1;
          o_ram_we    <= 1'b1;
          o_ram_addr  <= hold_addr;
          o_ram_wdata <= hold_data;
        end
        default: begin
          o_ram_en <= 1'b0;
          o_ram_we <= 1'b0;
        end
      endcase
    end
  end

  // Ready is ~hold_valid, so a load and a drain never fall in the same cycle.
  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      o_wr_drop  <= 1'b0;
    end else begin
      o_wr_drop <= wr_accept & ~wr_in_range;
      if (wr_accept & wr_in_range) begin
        hold_valid <= 1'b1;
        hold_addr  <= i_wr_addr;
        hold_data  <= i_wr_data;
      end else if (slot == SLOT_WRITE) begin
        hold_valid <= 1'b0;
      end
    end
  end

  logic rd_issued;
  logic video_pre;

  vga_sig_delay #(
    .W (3),
    .N (PIX_LAT)
  ) u_strobe_dly (
    .clk   (i_clk25m),
    .rst_n (i_rstn_clk25m),
    .d     ({i_VGA_video, i_VGA_hsync, i_VGA_vsync}),
    .q     ({o_video_d, o_hsync_d, o_vsync_d})
  );

  // video_pre is the video strobe one stage short, i.e. o_video_d's next value.
  vga_sig_delay #(
    .W (2),
    .N (PIX_LAT - 1)
  ) u_read_dly (
    .clk   (i_clk25m),
    .rst_n (i_rstn_clk25m),
    .d     ({read_slot, i_VGA_video}),
    .q     ({rd_issued, video_pre})
  );

  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m)  o_pixel_data <= '0;
    else if (!video_pre) o_pixel_data <= '0;
    else if (rd_issued)  o_pixel_data <= i_ram_rdata;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a small synthetic raster and behavioural frame-buffer model.
module tb_vga_fb_arbiter;

`ifdef VGA_FB_SCALE2X_EN
  localparam int S      = 1;
  localparam int SRC_W  = 8;
  localparam int SRC_H  = 3;
  localparam int ADDR_W = 5;
`else
  localparam int S      = 0;
  localparam int SRC_W  = 16;
  localparam int SRC_H  = 6;
  localparam int ADDR_W = 7;
`endif
  localparam int DATA_W = 12;
  localparam int H_ACT  = 16;
  localparam int H_TOT  = 22;
  localparam int V_ACT  = 6;
  localparam int V_TOT  = 9;
  localparam int NPIX   = SRC_W * SRC_H;
  localparam int MEMSZ  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic [9:0]        vga_x, vga_y;
  logic              vga_video, vga_hsync, vga_vsync;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_drop;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] pixel;
  logic              video_d, hsync_d, vsync_d;

  always #20 clk = ~clk;

  vga_fb_arbiter #(
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .i_clk25m      (clk),
    .i_rstn_clk25m (rstn),
    .i_VGA_x       (vga_x),
    .i_VGA_y       (vga_y),
    .i_VGA_video   (vga_video),
    .i_VGA_hsync   (vga_hsync),
    .i_VGA_vsync   (vga_vsync),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .o_wr_drop     (wr_drop),
    .o_ram_en      (ram_en),
    .o_ram_we      (ram_we),
    .o_ram_addr    (ram_addr),
    .o_ram_wdata   (ram_wdata),
    .i_ram_rdata   (ram_rdata),
    .o_pixel_data  (pixel),
    .o_video_d     (video_d),
    .o_hsync_d     (hsync_d),
    .o_vsync_d     (vsync_d)
  );

  // Single-port synchronous RAM seeded with the same contents as the model.
  logic [DATA_W-1:0] seed_mem [MEMSZ];
  logic [DATA_W-1:0] ref_mem  [MEMSZ];
  logic [DATA_W-1:0] ram      [MEMSZ];
  logic              ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < MEMSZ; i++) ram[i] <= seed_mem[i];
      ram_loaded <= 1'b1;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic              video, hs, vs;
    logic [DATA_W-1:0] pix;
  } disp_t;
  typedef struct {
    bit                rd;
    logic [ADDR_W-1:0] addr;
  } rd_t;
  typedef struct {
    int                edge_no;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  disp_t disp_q[$];
  rd_t   rd_q[$];
  wr_t   wq[$];
  bit    drop_at[int];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit xfer   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_en"},  32'(ram_en),    0);
    chk({tag, "_ram_we"},  32'(ram_we),    0);
    chk({tag, "_ram_addr"},32'(ram_addr),  0);
    chk({tag, "_ram_wdat"},32'(ram_wdata), 0);
    chk({tag, "_pixel"},   32'(pixel),     0);
    chk({tag, "_strobes"}, 32'({video_d, hsync_d, vsync_d}), 0);
    chk({tag, "_drop"},    32'(wr_drop),   0);
    chk({tag, "_ready"},   32'(wr_ready),  1);
  endtask

  // Display monitor: one output per cycle, compared against the model queue.
  disp_t de;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (disp_q.size() == 0) begin
        errors++;
        $display("FAIL disp_underflow: got empty queue expected entry");
      end else begin
        de = disp_q.pop_front();
        if ({video_d, hsync_d, vsync_d, pixel} !== {de.video, de.hs, de.vs, de.pix}) begin
          errors++;
          $display("FAIL disp: got v%0b h%0b s%0b pix %03h expected v%0b h%0b s%0b pix %03h",
                   video_d, hsync_d, vsync_d, pixel, de.video, de.hs, de.vs, de.pix);
        end
      end
    end
  end

  // RAM-command monitor: reads are fixed by the raster; writes drain in order into free slots.
  rd_t rc;
  wr_t wc;
  bit  cmd_ok;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_underflow: got empty queue expected entry");
      end else begin
        rc = rd_q.pop_front();
        if (rc.rd) begin
          cmd_ok = (ram_en === 1'b1) && (ram_we === 1'b0) && (ram_addr === rc.addr);
          if (!cmd_ok)
            $display("FAIL cmd_read: got en%0b we%0b addr %0h expected en1 we0 addr %0h",
                     ram_en, ram_we, ram_addr, rc.addr);
        end else if (wq.size() > 0 && wq[0].edge_no < cyc) begin
          wc = wq.pop_front();
          cmd_ok = (ram_en === 1'b1) && (ram_we === 1'b1) && (ram_addr === wc.addr)
                   && (ram_wdata === wc.data);
          if (!cmd_ok)
            $display("FAIL cmd_write: got en%0b we%0b addr %0h data %03h expected en1 we1 addr %0h data %03h",
                     ram_en, ram_we, ram_addr, ram_wdata, wc.addr, wc.data);
        end else begin
          cmd_ok = (ram_en === 1'b0);
          if (!cmd_ok)
            $display("FAIL cmd_idle: got en%0b we%0b addr %0h expected en0", ram_en, ram_we, ram_addr);
        end
        if (!cmd_ok) errors++;
      end
      checks++;
      if (wr_drop !== drop_at.exists(cyc)) begin
        errors++;
        $display("FAIL drop: got %0b expected %0b", wr_drop, drop_at.exists(cyc));
      end
      if (drop_at.exists(cyc)) drop_at.delete(cyc);
      checks++;
      if (wr_ready !== (wq.size() == 0)) begin
        errors++;
        $display("FAIL ready: got %0b expected %0b", wr_ready, wq.size() == 0);
      end
    end
  end

  task automatic start_mon();
    disp_t z;
    rd_t   ri;
    z  = '{video: 1'b0, hs: 1'b0, vs: 1'b0, pix: '0};
    ri = '{rd: 1'b0, addr: '0};
    disp_q.delete();
    rd_q.delete();
    wq.delete();
    drop_at.delete();
    repeat (3) disp_q.push_back(z);
    rd_q.push_back(ri);
    mon_en = 1'b1;
  endtask

  task automatic drive_cycle(input int x, input int y);
    disp_t d;
    rd_t   r;
    int    a;
    bit    v;
    v         = (x < H_ACT) && (y < V_ACT);
    vga_x     = 10'(x);
    vga_y     = 10'(y);
    vga_video = v;
    vga_hsync = (x >= 18) && (x < 20);
    vga_vsync = (y == 7);
    a         = (y >> S) * SRC_W + (x >> S);
    r.rd      = v && (S == 0 || (x % 2) == 0);
    r.addr    = a[ADDR_W-1:0];
    d.video   = v;
    d.hs      = vga_hsync;
    d.vs      = vga_vsync;
    d.pix     = v ? ref_mem[a] : '0;
    rd_q.push_back(r);
    disp_q.push_back(d);
  endtask

  // Writes target only rows already displayed this frame, so reads never race a pending write.
  task automatic step(input int x, input int y, input int pct);
    int lim;
    @(posedge clk); #1;
    if (xfer) begin
      wr_valid = 1'b0;
      xfer     = 1'b0;
    end
    drive_cycle(x, y);
    if (y < V_ACT)          lim = (y >> S) * SRC_W;
    else if (y == V_TOT-1)  lim = 0;
    else                    lim = NPIX;
    if (!wr_valid && $urandom_range(99) < pct && y != V_TOT-1) begin
      wr_data = DATA_W'($urandom);
      if ($urandom_range(7) == 0) begin
        wr_addr  = ADDR_W'(NPIX + $urandom_range(MEMSZ - 1 - NPIX));
        wr_valid = 1'b1;
      end else if (lim > 0) begin
        wr_addr  = ADDR_W'($urandom_range(lim - 1));
        wr_valid = 1'b1;
      end
    end
    @(negedge clk); #1;
    if (wr_valid && wr_ready) begin
      if (int'(wr_addr) < NPIX) begin
        wq.push_back('{edge_no: cyc + 1, addr: wr_addr, data: wr_data});
        ref_mem[wr_addr] = wr_data;
      end else begin
        drop_at[cyc + 1] = 1'b1;
      end
      xfer = 1'b1;
    end
  endtask

  task automatic run_frames(input int nf, input int pct);
    for (int f = 0; f < nf; f++)
      for (int y = 0; y < V_TOT; y++)
        for (int x = 0; x < H_TOT; x++)
          step(x, y, pct);
  endtask

  task automatic idle_inputs();
    vga_x = '0; vga_y = '0;
    vga_video = 1'b0; vga_hsync = 1'b0; vga_vsync = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    xfer = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) begin
      seed_mem[i] = DATA_W'($urandom);
      ref_mem[i]  = seed_mem[i];
    end
    idle_inputs();
    rstn = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_hold");
    rstn = 1'b1;
    #1;
    chk_reset_outputs("rst_rel");
    start_mon();

    run_frames(2, 30);
    run_frames(2, 100);
    run_frames(2, 60);
    run_frames(1, 0);

    // Reset with a write sitting in the hold register.
    for (int x = 0; x < 3; x++) step(x, 2, 0);
    @(posedge clk); #1;
    drive_cycle(3, 2);
    wr_addr  = ADDR_W'(5);
    wr_data  = ~ref_mem[5];
    wr_valid = 1'b1;
    @(negedge clk); #1;
    chk("midrst_accept_ready", 32'(wr_ready), 1);
    @(posedge clk); #1;
    drive_cycle(4, 2);
    chk("midrst_hold_full", 32'(wr_ready), 0);
    mon_en = 1'b0;
    rstn   = 1'b0;
    idle_inputs();
    #1;
    chk_reset_outputs("midrst_in");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk_reset_outputs("midrst_rel");
    start_mon();

    run_frames(2, 40);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
